// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction-fetch stage and its helpers:
//   - fetch_state_e : fetch controller states (BOOT / RUN / HALT)
//   - INSTR_W       : instruction word width
//   - NOP_INSTR     : canonical NOP (addi x0, x0, 0), used to fill empty slots
//   - align_pc()    : clears the byte-offset bits of a redirect target
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles every non-clock/reset signal of the fetch stage.
//   mb_if__jump_target / mb_if__jump_taken : redirect from memory/branch stage
//   id_stall                               : decode back-pressure
//   imem_read / imem_addr / imem_rdata     : synchronous instruction memory
//   if_id__pc / instr / valid / misaligned : fetch -> decode payload
// Modports:
//   master : the fetch stage itself
//   slave  : the environment (branch unit, decode, imem)
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int unsigned IMEM_AW = 11
);
  import instr_fetch_pkg::*;

  logic [31:0]         mb_if__jump_target;
  logic                mb_if__jump_taken;
  logic                id_stall;
  logic                imem_read;
  logic [IMEM_AW-1:0]  imem_addr;
  logic [INSTR_W-1:0]  imem_rdata;
  logic [31:0]         if_id__pc;
  logic [INSTR_W-1:0]  if_id__instr;
  logic                if_id__valid;
  logic                if_id__misaligned;

  modport master (
    input  mb_if__jump_target, mb_if__jump_taken, id_stall, imem_rdata,
    output imem_read, imem_addr, if_id__pc, if_id__instr, if_id__valid,
           if_id__misaligned
  );

  modport slave (
    output mb_if__jump_target, mb_if__jump_taken, id_stall, imem_rdata,
    input  imem_read, imem_addr, if_id__pc, if_id__instr, if_id__valid,
           if_id__misaligned
  );

endinterface

// File: rtl/instr_fetch_if_skid.sv
// -----------------------------------------------------------------------------
// if_skid
// One-entry pc/instr holding register for a pipeline stage boundary.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   flush                : drop the held entry (highest priority)
//   capture              : load in_pc/in_instr (only meaningful when empty)
//   release_en           : consumer took the held entry, mark empty
//   in_pc, in_instr      : entry to capture
//   out_valid            : an entry is held
//   out_pc, out_instr    : held entry
// -----------------------------------------------------------------------------
module if_skid
  import instr_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               capture,
  input  logic               release_en,
  input  logic [31:0]        in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  output logic [31:0]        out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  logic               valid_q, valid_d;
  logic [31:0]        pc_q,    pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
    end else if (release_en) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset as well; it is only two words, and a known
      // value keeps the empty slot deterministic rather than X.
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency synchronous
// instruction memory and presents pc/instr pairs to decode. A one-entry skid
// buffer (if_skid) absorbs the word returned while decode is stalled.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : instr_fetch_if.master (redirect in, id_stall in, imem port,
//          if_id payload out)
// Parameters:
//   RESET_PC : PC loaded on reset
//   IMEM_AW  : imem word-address width, imem_addr = pc[IMEM_AW+1:2]
// Build option:
//   IF_MISALIGN_TRAP_EN : a redirect to a target with bits[1:0] != 0 parks
//   the stage in HALT and raises if_id__misaligned until the next aligned
//   redirect. Without it the low bits are silently cleared.
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_if.master        bus
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               req_valid_q, req_valid_d;
  logic [31:0]        req_pc_q, req_pc_d;

  logic               hold_valid;
  logic [31:0]        hold_pc;
  logic [INSTR_W-1:0] hold_instr;

  logic               present_any;
  logic               pres_valid;
  logic [31:0]        pres_pc;
  logic [INSTR_W-1:0] pres_instr;
  logic               accept;
  logic               capture;
  logic               issue;

  // ---------------------------------------------------------------------------
  // Presentation: the held entry is always older than an in-flight read, so it
  // wins. A redirect cycle never presents, which also discards any accept.
  // ---------------------------------------------------------------------------
  always_comb begin
    present_any = 1'b0;
    pres_pc     = '0;
    pres_instr  = '0;
    if (hold_valid) begin
      present_any = 1'b1;
      pres_pc     = hold_pc;
      pres_instr  = hold_instr;
    end else if (req_valid_q) begin
      present_any = 1'b1;
      pres_pc     = req_pc_q;
      pres_instr  = bus.imem_rdata;
    end
    pres_valid = present_any && !bus.mb_if__jump_taken;
    accept     = pres_valid && !bus.id_stall;
    // The memory only holds its data for one cycle, so a stalled returning
    // word must be parked right away.
    capture    = bus.id_stall && req_valid_q && !hold_valid && !bus.mb_if__jump_taken;
  end

  if_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.mb_if__jump_taken),
    .capture    (capture),
    .release_en (accept && hold_valid),
    .in_pc      (req_pc_q),
    .in_instr   (bus.imem_rdata),
    .out_valid  (hold_valid),
    .out_pc     (hold_pc),
    .out_instr  (hold_instr)
  );

  // ---------------------------------------------------------------------------
  // Fetch controller: next state, PC and read issue.
  // A read is withheld only while decode is stalled on a presented entry; in
  // that case the one word still in flight lands in the skid buffer, so the
  // buffer can never be asked to hold two entries.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;

    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  issue   = !(bus.id_stall && present_any);
      default: issue   = 1'b0;
    endcase

    if (bus.mb_if__jump_taken) begin
      issue = 1'b0;
      pc_d  = align_pc(bus.mb_if__jump_target);
`ifdef IF_MISALIGN_TRAP_EN
      state_d = (bus.mb_if__jump_target[1:0] != 2'b00) ? ST_HALT : ST_RUN;
`endif
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end

    req_valid_d = issue;
    req_pc_d    = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.imem_read    = issue;
  assign bus.imem_addr    = pc_q[IMEM_AW+1:2];
  assign bus.if_id__pc    = pres_pc;
  assign bus.if_id__instr = pres_instr;
  assign bus.if_id__valid = pres_valid;

`ifdef IF_MISALIGN_TRAP_EN
  // HALT is only ever entered by a misaligned redirect, so the state register
  // doubles as the registered fault flag.
  assign bus.if_id__misaligned = (state_q == ST_HALT);
`else
  assign bus.if_id__misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch with RESET_PC = 0x100. The instruction memory
// model returns 0xA000_0000 + word_address one cycle after a read.
// Inputs change 1 time unit after a rising edge; outputs are compared 1 time
// unit later, well away from the next edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam int unsigned AW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_fetch_if #(.IMEM_AW(AW)) bus ();

  instr_fetch #(
    .RESET_PC (32'h0000_0100),
    .IMEM_AW  (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous-read memory model.
  always @(posedge clk) begin
    if (bus.imem_read)
      bus.imem_rdata <= 32'hA000_0000 + 32'(bus.imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, apply inputs, let outputs settle.
  task automatic next_cycle(input logic jt, input logic [31:0] tgt, input logic st);
    @(posedge clk);
    #1;
    bus.mb_if__jump_taken  = jt;
    bus.mb_if__jump_target = tgt;
    bus.id_stall           = st;
    #1;
  endtask

  task automatic check_present(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, 32'(bus.if_id__valid), 32'd1);
    check({tag, "_pc"},    bus.if_id__pc,         pc);
    check({tag, "_instr"}, bus.if_id__instr,      instr);
  endtask

  initial begin
    bus.mb_if__jump_taken  = 1'b0;
    bus.mb_if__jump_target = '0;
    bus.id_stall           = 1'b0;
    bus.imem_rdata         = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 32'(bus.if_id__valid),      32'd0);
    check("rst_read",  32'(bus.imem_read),         32'd0);
    check("rst_pc",    bus.if_id__pc,              32'd0);
    check("rst_instr", bus.if_id__instr,           32'd0);
    check("rst_mis",   32'(bus.if_id__misaligned), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ---- BOOT cycle, then first read ----
    next_cycle(1'b0, '0, 1'b0);
    check("boot1_valid", 32'(bus.if_id__valid), 32'd0);
    check("boot1_read",  32'(bus.imem_read),    32'd1);
    check("boot1_addr",  32'(bus.imem_addr),    32'h40);
    next_cycle(1'b0, '0, 1'b0);
    check_present("s0", 32'h100, 32'hA000_0040);
    next_cycle(1'b0, '0, 1'b0);
    check_present("s1", 32'h104, 32'hA000_0041);

    // ---- stall 3 cycles on 0x108 ----
    next_cycle(1'b0, '0, 1'b1);
    check_present("stall0", 32'h108, 32'hA000_0042);
    check("stall0_read", 32'(bus.imem_read), 32'd0);
    next_cycle(1'b0, '0, 1'b1);
    check_present("stall1", 32'h108, 32'hA000_0042);
    next_cycle(1'b0, '0, 1'b1);
    check_present("stall2", 32'h108, 32'hA000_0042);
    next_cycle(1'b0, '0, 1'b0);
    check_present("unstall", 32'h108, 32'hA000_0042);
    check("unstall_read", 32'(bus.imem_read), 32'd1);
    next_cycle(1'b0, '0, 1'b0);
    check_present("after_stall", 32'h10C, 32'hA000_0043);

    // ---- redirect while stalled with hold full ----
    next_cycle(1'b0, '0, 1'b1);
    check_present("pre_jump", 32'h110, 32'hA000_0044);
    next_cycle(1'b1, 32'h0000_0200, 1'b1);
    check("jump_valid", 32'(bus.if_id__valid), 32'd0);
    check("jump_read",  32'(bus.imem_read),    32'd0);
    next_cycle(1'b0, '0, 1'b0);
    check("jump1_valid", 32'(bus.if_id__valid), 32'd0);
    check("jump1_addr",  32'(bus.imem_addr),    32'h80);
    next_cycle(1'b0, '0, 1'b0);
    check_present("jump2", 32'h200, 32'hA000_0080);

    // ---- async reset mid-stream with hold full ----
    next_cycle(1'b0, '0, 1'b1);
    check_present("pre_rst0", 32'h204, 32'hA000_0081);
    next_cycle(1'b0, '0, 1'b1);
    check_present("pre_rst1", 32'h204, 32'hA000_0081);
    #1 rst = 1'b1;
    bus.id_stall = 1'b0;
    #1;
    check("arst_valid", 32'(bus.if_id__valid), 32'd0);
    check("arst_pc",    bus.if_id__pc,         32'd0);
    check("arst_instr", bus.if_id__instr,      32'd0);
    check("arst_read",  32'(bus.imem_read),    32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    next_cycle(1'b0, '0, 1'b0);
    check("rboot_valid", 32'(bus.if_id__valid), 32'd0);
    check("rboot_addr",  32'(bus.imem_addr),    32'h40);
    next_cycle(1'b0, '0, 1'b0);
    check_present("restart", 32'h100, 32'hA000_0040);

    // ---- PC wrap ----
    next_cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
    check("wrapj_valid", 32'(bus.if_id__valid), 32'd0);
    next_cycle(1'b0, '0, 1'b0);
    check("wrap_addr", 32'(bus.imem_addr), 32'h7FF);
    next_cycle(1'b0, '0, 1'b0);
    check_present("wrap0", 32'hFFFF_FFFC, 32'hA000_07FF);
    next_cycle(1'b0, '0, 1'b0);
    check_present("wrap1", 32'h0000_0000, 32'hA000_0000);

    // ---- misaligned redirect ----
    next_cycle(1'b1, 32'h0000_0202, 1'b0);
    check("misj_valid", 32'(bus.if_id__valid), 32'd0);
    next_cycle(1'b0, '0, 1'b0);
`ifdef IF_MISALIGN_TRAP_EN
    check("halt0_mis",   32'(bus.if_id__misaligned), 32'd1);
    check("halt0_read",  32'(bus.imem_read),         32'd0);
    check("halt0_valid", 32'(bus.if_id__valid),      32'd0);
    next_cycle(1'b0, '0, 1'b0);
    check("halt1_mis",   32'(bus.if_id__misaligned), 32'd1);
    check("halt1_read",  32'(bus.imem_read),         32'd0);
    next_cycle(1'b1, 32'h0000_0300, 1'b0);
    check("hjump_mis",   32'(bus.if_id__misaligned), 32'd1);
    check("hjump_valid", 32'(bus.if_id__valid),      32'd0);
    next_cycle(1'b0, '0, 1'b0);
    check("run_mis",  32'(bus.if_id__misaligned), 32'd0);
    check("run_read", 32'(bus.imem_read),         32'd1);
    check("run_addr", 32'(bus.imem_addr),         32'hC0);
    next_cycle(1'b0, '0, 1'b0);
    check_present("hexit", 32'h300, 32'hA000_00C0);
`else
    check("mis0_mis",  32'(bus.if_id__misaligned), 32'd0);
    check("mis0_read", 32'(bus.imem_read),         32'd1);
    check("mis0_addr", 32'(bus.imem_addr),         32'h80);
    next_cycle(1'b0, '0, 1'b0);
    check_present("mis_clr", 32'h200, 32'hA000_0080);
    check("mis1_mis", 32'(bus.if_id__misaligned), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage that consumes the memory/branch stage's redirect (mb_if__jump_target, mb_if__jump_taken) and feeds decode with pc/instr pairs.
- Owns the PC register and drives a synchronous-read instruction memory with 1-cycle read latency.
- Holds a one-entry skid buffer so a decode stall never loses a returned instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_AW, 11, imem word-address width; imem_addr = pc[IMEM_AW+1:2].

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active-high
- mb_if__jump_target  in  32  redirect target from memory/branch stage
- mb_if__jump_taken  in  1  redirect strobe, single-cycle
- id_stall  in  1  decode cannot accept this cycle
- imem_read  out  1  read enable to instruction memory
- imem_addr  out  IMEM_AW  word address to instruction memory
- imem_rdata  in  32  instruction word, valid the cycle after imem_read=1
- if_id__pc  out  32  pc of presented instruction
- if_id__instr  out  32  presented instruction
- if_id__valid  out  1  pc/instr valid this cycle
- if_id__misaligned  out  1  misaligned-target fault (optional feature only, else tied 0)

Behaviour:
- Reset (async, any time, mid-operation included): pc=RESET_PC, req_valid=0, hold_valid=0, state=BOOT. Outputs: imem_read=0, if_id__valid=0, if_id__pc=0, if_id__instr=0, if_id__misaligned=0.
- State machine:
  - BOOT: one cycle after reset release, no read issued, then RUN.
  - RUN: normal fetch.
  - HALT: optional feature only.
- Internal request register: req_valid, req_pc mark a read issued last cycle.
- Presented data:
  - if hold_valid: present hold_pc/hold_instr.
  - else if req_valid: present req_pc/imem_rdata.
  - else if_id__valid=0.
  - if_id__valid is forced 0 in any cycle mb_if__jump_taken=1.
- Accept: the presented entry is consumed when if_id__valid=1 and id_stall=0.
- Issue rule in RUN: imem_read=1 and pc advances by 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0) iff not (id_stall and an entry is presented). req_valid<=imem_read; req_pc<=pc.
- Skid: if id_stall=1, req_valid=1 and hold_valid=0, capture req_pc/imem_rdata into hold the same cycle. Hold is released on accept. At most one entry is outstanding beyond hold, so there is no overflow.
- Redirect (highest priority, overrides stall):
  - pc<=mb_if__jump_target with bits[1:0] cleared.
  - req_valid<=0, hold_valid<=0, no read issued that cycle.
  - First target instruction is presented 2 cycles after the jump_taken cycle.
- Simultaneous jump_taken and accept: the accept is ignored (valid forced 0).
- Throughput: 1 instr/cycle with no stall. Latency from pc issue to presentation is 1 cycle.

Optional Feature:
- Macro IF_MISALIGN_TRAP_EN.
- Defined: a redirect with target[1:0]!=0 enters HALT.
  - In HALT: no reads, if_id__valid=0, if_id__misaligned=1 (registered, asserted the cycle after redirect).
  - The next jump_taken with an aligned target returns to RUN and clears misaligned; a misaligned one re-enters HALT.
- Undefined: low bits silently cleared, HALT unreachable, if_id__misaligned tied 0.

Decomposition:
- Shared core package: the fetch state enum (BOOT/RUN/HALT), the NOP constant 32'h0000_0013, the instruction-width constant 32.
- One natural sub-module: if_skid (1-entry pc/instr holding register with capture/release), reusable at other stage boundaries.

Test Plan:
- Reset release, RESET_PC=0x100, imem word n = 0xA000_0000+n, id_stall=0 -> valid first at cycle 2; pcs 0x100, 0x104, 0x108 on consecutive cycles, instrs 0xA000_0040, 0xA000_0041, ...
- id_stall high 3 cycles while pc 0x108 presented -> 0x108 held stable with valid=1; after release 0x10C follows with no gap, no duplicate, no loss.
- jump_taken with target 0x200 while stalled with hold full -> valid=0 that cycle; hold flushed; next valid pc is 0x200 exactly 2 cycles later.
- rst asserted asynchronously mid-stream with hold full -> outputs 0 immediately; after release, fetch restarts at RESET_PC.
- PC wrap: jump to 0xFFFF_FFFC, no stall -> pcs 0xFFFF_FFFC then 0x0000_0000.
- IF_MISALIGN_TRAP_EN: jump to 0x202 -> misaligned=1 and no reads; then jump to 0x300 -> misaligned=0 and pc 0x300 presented 2 cycles later. Without the macro, 0x202 fetches 0x200.
